// File: rtl/mul_issue_ctrl_if.sv
// rtl/mul_issue_ctrl_if.sv - operand stream, multiplier port and result stream bundle
interface mul_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_mlier;
  logic [31:0]               in_mcand;
  logic                      m_start;
  logic [31:0]               m_mlier;
  logic [31:0]               m_mcand;
  logic [63:0]               m_prodt;
  logic                      m_valid;
  logic                      out_valid;
  logic                      out_ready;
  logic [63:0]               out_prodt;
  logic [7:0]                out_lat;
  logic                      err_timeout;
  logic [$clog2(DEPTH):0]    fifo_count;

  modport master (
    input  in_valid, in_mlier, in_mcand, m_prodt, m_valid, out_ready,
    output in_ready, m_start, m_mlier, m_mcand, out_valid, out_prodt,
           out_lat, err_timeout, fifo_count
  );

  modport slave (
    output in_valid, in_mlier, in_mcand, m_prodt, m_valid, out_ready,
    input  in_ready, m_start, m_mlier, m_mcand, out_valid, out_prodt,
           out_lat, err_timeout, fifo_count
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - operand FIFO, multiplier start sequencing and result capture
module mul_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int MAX_LAT = 40
) (
  input logic           clock,
  input logic           reset,
  mul_issue_ctrl_if.master bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE   = 1;
  localparam logic [AW-1:0]   PTR_ONE   = 1;
  localparam logic [7:0]      LAT_LIMIT = 8'(MAX_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t         state, state_nxt;
  logic [63:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [63:0]    head;
  logic           push, pop, launch_ok;
  logic           done_hit, expire_hit;
  logic [7:0]     lat_cnt;
  logic [7:0]     lat_inc;

  // Full FIFO refuses pushes regardless of a same-cycle pop, so ready depends on count alone.
  assign bus.in_ready = (count != FULL_CNT);
  assign bus.fifo_count = count;
  assign push = bus.in_valid && bus.in_ready;
  // Never launch while a result is parked and not being taken this cycle.
  assign launch_ok = (count != '0) && (!bus.out_valid || bus.out_ready);
  assign head = mem[rd_ptr];
  assign lat_inc = lat_cnt + 8'd1;

  // Sequencer next state: load/pop on launch, finish on valid or watchdog expiry.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    done_hit   = 1'b0;
    expire_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch_ok) begin
          pop       = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.m_valid) begin
          done_hit  = 1'b1;
          state_nxt = S_GAP;
        end else if (lat_inc == LAT_LIMIT) begin
          expire_hit = 1'b1;
          state_nxt  = S_GAP;
        end
      end
      S_GAP: begin
        if (launch_ok) begin
          pop       = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FIFO storage; contents are don't-care when the pointers say empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {bus.in_mlier, bus.in_mcand};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Multiplier drive: start follows the next state so it is a clean flop output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.m_start <= 1'b0;
      bus.m_mlier <= '0;
      bus.m_mcand <= '0;
      lat_cnt     <= '0;
    end else begin
      bus.m_start <= (state_nxt == S_RUN);
      if (pop) begin
        bus.m_mlier <= head[63:32];
        bus.m_mcand <= head[31:0];
        lat_cnt     <= '0;
      end else if (state == S_RUN) begin
        lat_cnt <= lat_inc;
      end
    end
  end

  // Result register and sticky watchdog flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_prodt   <= '0;
      bus.out_lat     <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      if (done_hit) begin
        bus.out_valid <= 1'b1;
        bus.out_prodt <= bus.m_prodt;
        bus.out_lat   <= lat_inc;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (expire_hit) bus.err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl
module tb_mul_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int MAX_LAT = 40;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mul_issue_ctrl_if #(.DEPTH(DEPTH)) bus();
  mul_issue_ctrl #(.DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Multiplier model: valid in the lat_l-th start cycle; lat_l==0 never answers.
  int   lat_l = 0;
  logic stray = 1'b0;
  int   mcyc;
  logic model_fire;
  always @(posedge clock or posedge reset) begin
    if (reset)            mcyc <= 0;
    else if (bus.m_start) mcyc <= mcyc + 1;
    else                  mcyc <= 0;
  end
  assign model_fire  = bus.m_start && (lat_l != 0) && (mcyc + 1 == lat_l);
  assign bus.m_valid = model_fire || stray;
  assign bus.m_prodt = model_fire ? ref_mul(bus.m_mlier, bus.m_mcand) : 64'hdead_beef_0bad_f00d;

  // Monitor: records accepted results and m_start high/low run lengths.
  logic        mon_reset = 1'b0;
  int          run_len, low_len;
  logic        seen_high;
  int          runs_q[$];
  int          gaps_q[$];
  logic [71:0] res_q[$];
  logic [63:0] exp_q[$];
  always @(posedge clock) begin
    if (reset || mon_reset) begin
      run_len <= 0; low_len <= 0; seen_high <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) res_q.push_back({bus.out_lat, bus.out_prodt});
      if (bus.m_start) begin
        if (seen_high && low_len > 0) gaps_q.push_back(low_len);
        low_len <= 0; run_len <= run_len + 1; seen_high <= 1'b1;
      end else begin
        if (run_len > 0) runs_q.push_back(run_len);
        run_len <= 0; low_len <= low_len + 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic mon_clear();
    mon_reset = 1'b1;
    @(negedge clock);
    mon_reset = 1'b0;
    runs_q.delete(); gaps_q.delete(); res_q.delete(); exp_q.delete();
  endtask

  // Offers a pair from a negedge; keeps in_valid high if not taken within budget.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input int budget, output bit ok);
    bus.in_valid = 1'b1; bus.in_mlier = a; bus.in_mcand = b; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      @(negedge clock);
    end
    if (ok) begin
      exp_q.push_back(ref_mul(a, b));
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (res_q.size() >= n) ok = 1'b1;
      else @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_mlier = '0; bus.in_mcand = '0; bus.out_ready = 1'b0;
    cyc(2);
    checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.m_start !== 1'b0) begin failures++; $display("FAIL reset_m_start got=%b exp=0", bus.m_start); end
    checks++; if ({bus.m_mlier, bus.m_mcand} !== 64'd0) begin failures++; $display("FAIL reset_operands got=%h exp=0", {bus.m_mlier, bus.m_mcand}); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_prodt !== 64'd0 || bus.out_lat !== 8'd0) begin failures++; $display("FAIL reset_out_regs got=%h/%0d exp=0/0", bus.out_prodt, bus.out_lat); end
    checks++; if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", bus.err_timeout); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_single();
    bit ok; logic [71:0] r;
    lat_l = 33; bus.out_ready = 1'b1;
    mon_clear();
    push_pair(32'h0000_0004, 32'h000f_ffff, 10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_push got=refused exp=accepted"); end
    wait_results(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_result got=none exp=1 result"); end
    else begin
      r = res_q.pop_front(); void'(exp_q.pop_front());
      checks++; if (r[63:0] !== 64'h0000_0000_003f_fffc) begin failures++; $display("FAIL single_prodt got=%h exp=00000000003ffffc", r[63:0]); end
      checks++; if (r[71:64] !== 8'd33) begin failures++; $display("FAIL single_lat got=%0d exp=33", r[71:64]); end
    end
    cyc(3);
    checks++; if (runs_q.size() != 1 || runs_q[0] != 33) begin failures++; $display("FAIL single_start_len got=%0d runs first=%0d exp=1 run of 33", runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [71:0] r; logic [63:0] e;
    lat_l = 33; bus.out_ready = 1'b1;
    mon_clear();
    push_pair(32'hffff_fffe, 32'h0000_0002, 10, ok);
    push_pair(32'h0000_0003, 32'h0000_0005, 10, ok);
    wait_results(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_results got=%0d exp=2", res_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        r = res_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r[63:0] !== e || r[71:64] !== 8'd33) begin failures++; $display("FAIL b2b_result%0d got=%h/%0d exp=%h/33", i, r[63:0], r[71:64], e); end
      end
    end
    cyc(3);
    checks++; if (gaps_q.size() != 1 || gaps_q[0] != 1) begin failures++; $display("FAIL b2b_gap got=%0d gaps first=%0d exp=1 gap of 1", gaps_q.size(), (gaps_q.size() > 0) ? gaps_q[0] : -1); end
  endtask

  task automatic test_fifo_full();
    bit ok; logic [71:0] r; logic [63:0] e; logic [63:0] held;
    logic [31:0] a6, b6;
    lat_l = 5; bus.out_ready = 1'b0;
    mon_clear();
    for (int i = 0; i < 5; i++) begin
      push_pair($urandom, $urandom, 10, ok);
      checks++; if (!ok) begin failures++; $display("FAIL full_accept%0d got=refused exp=accepted", i); end
    end
    a6 = $urandom; b6 = $urandom;
    push_pair(a6, b6, 20, ok);
    checks++; if (ok) begin failures++; $display("FAIL full_sixth got=accepted exp=refused"); end
    checks++; if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin failures++; $display("FAIL full_state got=ready%b/count%0d exp=ready0/count4", bus.in_ready, bus.fifo_count); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_prodt !== exp_q[0]) begin failures++; $display("FAIL full_parked got=%b/%h exp=1/%h", bus.out_valid, bus.out_prodt, exp_q[0]); end
    held = bus.out_prodt;
    cyc(10);
    checks++; if (bus.out_prodt !== held || bus.m_start !== 1'b0 || runs_q.size() != 1) begin failures++; $display("FAIL full_hold got=%h/start%b/runs%0d exp=%h/start0/runs1", bus.out_prodt, bus.m_start, runs_q.size(), held); end
    bus.out_ready = 1'b1;
    push_pair(a6, b6, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_sixth_late got=refused exp=accepted"); end
    wait_results(6, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_results got=%0d exp=6", res_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        r = res_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r[63:0] !== e || r[71:64] !== 8'd5) begin failures++; $display("FAIL full_result%0d got=%h/%0d exp=%h/5", i, r[63:0], r[71:64], e); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [71:0] r; logic [63:0] e;
    lat_l = 0; bus.out_ready = 1'b1;
    mon_clear();
    push_pair($urandom, $urandom, 10, ok);
    push_pair($urandom, $urandom, 10, ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.err_timeout === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    checks++; if (!ok) begin failures++; $display("FAIL timeout_flag got=0 exp=1"); end
    checks++; if (bus.m_start !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL timeout_gap got=start%b/valid%b exp=start0/valid0", bus.m_start, bus.out_valid); end
    lat_l = 7;
    void'(exp_q.pop_front());
    wait_results(1, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_next_result got=none exp=1 result"); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r[63:0] !== e || r[71:64] !== 8'd7) begin failures++; $display("FAIL timeout_next got=%h/%0d exp=%h/7", r[63:0], r[71:64], e); end
    end
    cyc(3);
    checks++; if (runs_q.size() != 2 || runs_q[0] != 40 || gaps_q.size() != 1 || gaps_q[0] != 1) begin failures++; $display("FAIL timeout_runs got=runs%0d first%0d gaps%0d exp=runs2 first40 gaps1 of 1", runs_q.size(), (runs_q.size() > 0) ? runs_q[0] : -1, gaps_q.size()); end
    checks++; if (bus.err_timeout !== 1'b1 || res_q.size() != 0) begin failures++; $display("FAIL timeout_sticky got=%b/extra%0d exp=1/0", bus.err_timeout, res_q.size()); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    lat_l = 0; bus.out_ready = 1'b1;
    mon_clear();
    for (int i = 0; i < 3; i++) push_pair($urandom, $urandom, 10, ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.m_start === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_launch got=no start exp=start"); end
    cyc(9);
    checks++; if (bus.fifo_count !== 3'd2 || bus.m_start !== 1'b1) begin failures++; $display("FAIL rst_pre got=count%0d/start%b exp=count2/start1", bus.fifo_count, bus.m_start); end
    reset = 1'b1;
    #1;
    checks++; if (bus.m_start !== 1'b0 || bus.fifo_count !== 3'd0 || bus.out_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin failures++; $display("FAIL rst_immediate got=start%b/count%0d/valid%b/err%b exp=0/0/0/0", bus.m_start, bus.fifo_count, bus.out_valid, bus.err_timeout); end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0; lat_l = 3;
    cyc(60);
    checks++; if (res_q.size() != 0 || runs_q.size() != 0 || bus.m_start !== 1'b0) begin failures++; $display("FAIL rst_after got=results%0d/runs%0d/start%b exp=0/0/0", res_q.size(), runs_q.size(), bus.m_start); end
  endtask

  task automatic test_stray_valid();
    bit ok; logic [71:0] r; logic [63:0] e;
    lat_l = 4; bus.out_ready = 1'b1;
    mon_clear();
    cyc(2);
    stray = 1'b1;
    cyc(1);
    stray = 1'b0;
    cyc(3);
    checks++; if (bus.out_valid !== 1'b0 || bus.m_start !== 1'b0 || res_q.size() != 0) begin failures++; $display("FAIL stray_ignored got=valid%b/start%b/results%0d exp=0/0/0", bus.out_valid, bus.m_start, res_q.size()); end
    push_pair($urandom, $urandom, 10, ok);
    wait_results(1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stray_followup got=none exp=1 result"); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r[63:0] !== e || r[71:64] !== 8'd4) begin failures++; $display("FAIL stray_result got=%h/%0d exp=%h/4", r[63:0], r[71:64], e); end
    end
  endtask

  task automatic test_random();
    bit ok; logic [71:0] r; logic [63:0] e; int n_ok;
    lat_l = $urandom_range(2, 12); bus.out_ready = 1'b1;
    mon_clear();
    n_ok = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          bit acc;
          push_pair($urandom, $urandom, 300, acc);
          if (acc) n_ok++;
          cyc($urandom_range(0, 3));
        end
      end
      begin
        for (int i = 0; i < 600; i++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        bus.out_ready = 1'b1;
      end
    join
    checks++; if (n_ok != 24) begin failures++; $display("FAIL rand_accepts got=%0d exp=24", n_ok); end
    wait_results(n_ok, 800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_results got=%0d exp=%0d", res_q.size(), n_ok); end
    else begin
      for (int i = 0; i < n_ok; i++) begin
        r = res_q.pop_front(); e = exp_q.pop_front();
        checks++; if (r[63:0] !== e || r[71:64] !== 8'(lat_l)) begin failures++; $display("FAIL rand_result%0d got=%h/%0d exp=%h/%0d", i, r[63:0], r[71:64], e, lat_l); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_reset_mid_run();
    test_stray_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
